syn_debug_monitor: RTL and testbench
====================================

# syn_debug_monitor

Board-side debug controller at the far end of the CPU top's debug port. It gates the CPU `en` input for free-run and single-step execution, and counts executed cycles. On request it freezes the CPU and reads state out through the debug ports: first the PC, then r0–r31, then a window of data-memory words. Each read-back word is emitted on a valid/ready stream toward the display/UART logic.

## Interface
Parameters:
- `DmAddrBit`, default 10: width of the data-memory debug address. Legal range 1..16.
- `DumpWords`, default 16: number of data-memory words per dump. Legal range 1..1024.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `run_req` in 1: level; 1 requests free-run.
- `step_req` in 1: one-cycle pulse; requests one enabled CPU cycle.
- `dump_req` in 1: one-cycle pulse; starts a dump.
- `dm_base` in DmAddrBit: first data-memory address of the dump; latched at dump start.
- `cpu_halt` in 1: CPU halt flag.
- `pc_dbg` in 32: CPU PC.
- `regfile_data_dbg` in 32: CPU register read data.
- `datamem_data_dbg` in 32: CPU data-memory read data.
- `cpu_en` out 1: CPU enable.
- `regfile_req_dbg` out 5: register debug address.
- `datamem_addr_dbg` out DmAddrBit: data-memory debug address.
- `out_valid` out 1, `out_ready` in 1: dump stream handshake.
- `out_data` out 32: dumped word.
- `out_kind` out 2: 0 = PC, 1 = register, 2 = memory; 3 is never emitted.
- `out_index` out 16: 0 for PC, register number, or memory address (zero-extended).
- `busy` out 1: high while a dump is in progress.
- `step_count` out 32: number of cycles with `cpu_en`=1.

## Operation
- States: IDLE, RUN, STEP, SETUP, SEND.
- IDLE transitions, in priority order:
  - `dump_req` → SETUP.
  - `step_req` and not `cpu_halt` → STEP.
  - `run_req` and not `cpu_halt` → RUN.
  - Otherwise stay in IDLE.
- RUN:
  - `dump_req` → SETUP.
  - Otherwise, `run_req`=0 or `cpu_halt`=1 → IDLE.
  - Otherwise stay in RUN.
- STEP: lasts exactly one cycle, then → IDLE.
- `cpu_en` = (RUN and `run_req` and not `cpu_halt` and not `dump_req`) or STEP.
  - Combinational from the state register and these inputs.
  - The CPU is never enabled in IDLE, SETUP or SEND.
- `step_count` increments on every clock edge where `cpu_en`=1; wraps 0xFFFFFFFF→0.
- Dump items, indexed by an item counter `idx` running 0..32+DumpWords:
  - `idx`=0: PC.
  - `idx`=1..32: register `idx`-1.
  - `idx`=33..: memory word at (latched `dm_base` + `idx`-33) mod 2^DmAddrBit; the address wraps.
- Dump sequencing:
  - On dump start: `idx`←0 and `dm_base` is latched.
  - SETUP: the debug addresses for `idx` are driven from registers and are stable for the whole cycle. At the SETUP edge, the selected data, `out_kind` and `out_index` are registered, `out_valid`←1, and state → SEND.
  - SEND: `out_valid`=1. `out_data`, `out_kind` and `out_index` are held stable until `out_ready`=1.
  - On handshake at the last item: `out_valid`←0 and state → IDLE.
  - On any other handshake: `out_valid`←0, `idx`++ and state → SETUP.
- Debug address outputs:
  - `regfile_req_dbg` = `idx`-1 during register items, otherwise it holds its value.
  - `datamem_addr_dbg` = the memory address during memory items, otherwise it holds its value.
- `busy` = state is SETUP or SEND.
- `step_req` and `dump_req` arriving during STEP, SETUP or SEND are dropped, not queued.
- A dump is allowed while `cpu_halt`=1; this is the main use case.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State → IDLE.
  - `cpu_en`, `out_valid` and `busy` = 0.
  - `regfile_req_dbg`, `datamem_addr_dbg`, `out_data`, `out_kind`, `out_index`, `step_count` and `idx` = 0.
- Reset mid-dump aborts the dump; no partial item remains valid.
- With `dump_req` at IDLE cycle 0:
  - SETUP occurs at cycle 1; the PC item is valid at cycle 2.
  - Each item takes 2 cycles when `out_ready` is tied high.
- Full dump with `out_ready`=1 and DumpWords=16 (49 items):
  - `busy` is high for cycles 1..98.
  - The last handshake is at cycle 98; IDLE at cycle 99.
- `out_ready` stalls lengthen SEND without bound; the CPU stays disabled throughout.
- Step: `step_req` at cycle 0 gives `cpu_en`=1 in cycle 1 only; `step_count` +1 at the end of cycle 1.
- Halt during RUN: `cpu_en` falls in the same cycle `cpu_halt` rises (combinational); state is IDLE at the next cycle.

## Test plan
- Reset mid-SEND, with `out_ready`=0 and `out_valid`=1 → `out_valid`=0 and `busy`=0 immediately; after release, `step_count`=0 and `cpu_en`=0.
- `run_req`=1 for 10 cycles, `cpu_halt` rising at cycle 6 → `cpu_en` high for 5 cycles, `step_count`=5, state IDLE; a later `step_req` while halted leaves `step_count`=5.
- Three `step_req` pulses spaced 4 cycles apart → exactly 3 single-cycle `cpu_en` pulses, `step_count`=3.
- Dump with `dm_base`=0x3FE, DumpWords=16, DmAddrBit=10, `out_ready`=1, CPU model returning PC=0x40, reg n = n*3, mem[a] = ~a:
  - 49 words in order: kind 0 with 0x40, then r0..r31 with values 0..93.
  - Memory indices 0x3FE, 0x3FF, 0x000..0x00D (address wraps).
  - `busy` falls at cycle 99.
- Dump with `out_ready` toggled pseudo-randomly → same 49-word sequence; outputs stable while `out_valid`=1 and `out_ready`=0.
- `dump_req` during RUN with `run_req` held → `cpu_en` is 0 in the request cycle and for the whole dump; RUN resumes after the dump; a second `dump_req` mid-dump is ignored (49 words total).

Source files
------------

// File: rtl/syn_debug_monitor.sv
// syn_debug_monitor: CPU run/step gating, cycle counting and debug-port state dump over a valid/ready stream
module syn_debug_monitor #(
    parameter int DmAddrBit = 10,
    parameter int DumpWords = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run_req,
    input  logic                 step_req,
    input  logic                 dump_req,
    input  logic [DmAddrBit-1:0] dm_base,
    input  logic                 cpu_halt,
    input  logic [31:0]          pc_dbg,
    input  logic [31:0]          regfile_data_dbg,
    input  logic [31:0]          datamem_data_dbg,
    output logic                 cpu_en,
    output logic [4:0]           regfile_req_dbg,
    output logic [DmAddrBit-1:0] datamem_addr_dbg,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data,
    output logic [1:0]           out_kind,
    output logic [15:0]          out_index,
    output logic                 busy,
    output logic [31:0]          step_count
);
    typedef enum logic [2:0] {IDLE, RUN, STEP, SETUP, SEND} state_t;

    state_t               state, state_nxt;
    logic                 start;
    logic [15:0]          idx;
    logic [15:0]          nidx;
    logic [DmAddrBit-1:0] base;
    logic [DmAddrBit-1:0] mem_nxt;
    logic                 last;
    logic                 hs;

    assign nidx    = idx + 16'd1;
    assign last    = idx == 16'(32 + DumpWords);
    assign hs      = state == SEND && out_ready;
    assign mem_nxt = base + DmAddrBit'(nidx - 16'd33);
    assign busy    = state == SETUP || state == SEND;
    assign cpu_en  = (state == RUN && run_req && !cpu_halt && !dump_req) || state == STEP;

    // Next-state selection; requests arriving outside IDLE/RUN are simply dropped
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: begin
                start     = dump_req;
                state_nxt = dump_req ? SETUP :
                            (step_req && !cpu_halt) ? STEP :
                            (run_req && !cpu_halt) ? RUN : IDLE;
            end
            RUN: begin
                start     = dump_req;
                state_nxt = dump_req ? SETUP : (!run_req || cpu_halt) ? IDLE : RUN;
            end
            STEP:    state_nxt = IDLE;
            SETUP:   state_nxt = SEND;
            SEND:    state_nxt = out_ready ? (last ? IDLE : SETUP) : SEND;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Executed-cycle counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      step_count <= 32'd0;
        else if (cpu_en) step_count <= step_count + 32'd1;
    end

    // Dump datapath: item counter, debug addresses for the next item, and the registered output word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx              <= 16'd0;
            base             <= '0;
            regfile_req_dbg  <= 5'd0;
            datamem_addr_dbg <= '0;
            out_valid        <= 1'b0;
            out_data         <= 32'd0;
            out_kind         <= 2'd0;
            out_index        <= 16'd0;
        end else begin
            if (start) begin
                idx  <= 16'd0;
                base <= dm_base;
            end
            if (state == SETUP) begin
                out_valid <= 1'b1;
                out_data  <= idx == 16'd0 ? pc_dbg : idx <= 16'd32 ? regfile_data_dbg : datamem_data_dbg;
                out_kind  <= idx == 16'd0 ? 2'd0 : idx <= 16'd32 ? 2'd1 : 2'd2;
                out_index <= idx == 16'd0 ? 16'd0 : idx <= 16'd32 ? idx - 16'd1 : 16'(datamem_addr_dbg);
            end
            if (hs) begin
                out_valid <= 1'b0;
                if (!last) begin
                    idx <= nidx;
                    if (nidx <= 16'd32) regfile_req_dbg  <= idx[4:0];
                    else                datamem_addr_dbg <= mem_nxt;
                end
            end
        end
    end
endmodule

// File: tb/tb_syn_debug_monitor.sv
// tb_syn_debug_monitor: directed checks of run/halt, stepping, dumps with stalls and reset abort
module tb_syn_debug_monitor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run_req = 1'b0, step_req = 1'b0, dump_req = 1'b0, cpu_halt = 1'b0, out_ready = 1'b0;
    logic [9:0]  dm_base = 10'h3FE;
    logic [31:0] pc_dbg = 32'h40;
    logic [31:0] regfile_data_dbg, datamem_data_dbg, out_data, step_count;
    logic        cpu_en, out_valid, busy;
    logic [4:0]  regfile_req_dbg;
    logic [9:0]  datamem_addr_dbg;
    logic [1:0]  out_kind;
    logic [15:0] out_index;
    int          checks = 0;
    int          errors = 0;
    int          k_got, fall_at, en_hi, unstable;
    logic [31:0] sc;

    syn_debug_monitor #(.DmAddrBit(10), .DumpWords(16)) dut (
        .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req), .dump_req(dump_req),
        .dm_base(dm_base), .cpu_halt(cpu_halt), .pc_dbg(pc_dbg),
        .regfile_data_dbg(regfile_data_dbg), .datamem_data_dbg(datamem_data_dbg),
        .cpu_en(cpu_en), .regfile_req_dbg(regfile_req_dbg), .datamem_addr_dbg(datamem_addr_dbg),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_kind(out_kind),
        .out_index(out_index), .busy(busy), .step_count(step_count)
    );

    always #5 clk = ~clk;

    // CPU model: reg n reads n*3, mem[a] reads ~a
    assign regfile_data_dbg = {27'd0, regfile_req_dbg} * 32'd3;
    assign datamem_data_dbg = ~{22'd0, datamem_addr_dbg};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_item(input int k);
        logic [9:0] a;
        a = 10'(32'h3FE + k - 33);
        if (k == 0) return {14'd0, 2'd0, 16'd0, 32'h40};
        if (k <= 32) return {14'd0, 2'd1, 16'(k - 1), 32'((k - 1) * 3)};
        return {14'd0, 2'd2, 6'd0, a, ~{22'd0, a}};
    endfunction

    // One full dump starting with dump_req in the next cycle; results in k_got/fall_at/en_hi/unstable
    task automatic do_dump(input bit rnd, input bit redump);
        logic [49:0] prev;
        bit          hold;
        hold     = 1'b0;
        prev     = '0;
        k_got    = 0;
        fall_at  = -1;
        en_hi    = 0;
        unstable = 0;
        cyc();
        dump_req  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("en_in_req_cycle", cpu_en, 0);
        for (int c = 1; c < 3000; c++) begin
            cyc();
            dump_req  = redump && c == 10;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (hold && {out_kind, out_index, out_data} !== prev) unstable++;
            if (cpu_en) en_hi++;
            if (!busy) begin
                fall_at = c;
                break;
            end
            if (out_valid && out_ready) begin
                if (k_got < 49) check($sformatf("item%0d", k_got), {14'd0, out_kind, out_index, out_data}, exp_item(k_got));
                k_got++;
            end
            hold = out_valid && !out_ready;
            prev = {out_kind, out_index, out_data};
        end
        dump_req  = 1'b0;
        out_ready = 1'b0;
        check("dump_count", 64'(k_got), 49);
        check("dump_en_hi", 64'(en_hi), 0);
        check("dump_stable", 64'(unstable), 0);
        if (!rnd) check("busy_fall_cycle", 64'(fall_at), 99);
        else check("dump_finished", 64'(fall_at > 0), 1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_cpu_en", cpu_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_step_count", step_count, 0);
        check("rst_outs", {out_kind, out_index, out_data, regfile_req_dbg, datamem_addr_dbg}, 0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // run with halt rising at cycle 6
        for (int c = 0; c < 10; c++) begin
            cyc();
            run_req  = 1'b1;
            cpu_halt = c >= 6;
            #1;
            check($sformatf("run_en_c%0d", c), cpu_en, c >= 1 && c <= 5);
        end
        cyc();
        run_req = 1'b0;
        #1;
        check("run_step_count", step_count, 5);
        cyc();
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        #1;
        check("halted_step_en", cpu_en, 0);
        cyc();
        #1;
        check("halted_step_count", step_count, 5);

        // three single steps, 4 cycles apart
        cpu_halt = 1'b0;
        for (int p = 0; p < 3; p++) begin
            cyc();
            step_req = 1'b1;
            #1;
            check("step_req_cycle_en", cpu_en, 0);
            cyc();
            step_req = 1'b0;
            #1;
            check("step_pulse_en", cpu_en, 1);
            cyc();
            #1;
            check("step_after_en", cpu_en, 0);
            cyc();
        end
        check("step_count_3", step_count, 8);

        // halted dump, ready tied high
        cpu_halt = 1'b1;
        do_dump(1'b0, 1'b0);
        check("dump1_step_count", step_count, 8);

        // halted dump with random back-pressure
        do_dump(1'b1, 1'b0);

        // dump during RUN with a second request mid-dump
        cpu_halt = 1'b0;
        run_req  = 1'b1;
        cyc();
        cyc();
        cyc();
        #1;
        check("run_before_dump", cpu_en, 1);
        sc = step_count;
        do_dump(1'b0, 1'b1);
        check("run_dump_step_count", step_count, 64'(sc + 32'd1));
        cyc();
        #1;
        check("run_resumes", cpu_en, 1);
        run_req = 1'b0;
        cyc();
        cyc();

        // reset while an item is stalled in SEND
        cyc();
        dump_req  = 1'b1;
        out_ready = 1'b0;
        cyc();
        dump_req = 1'b0;
        cyc();
        cyc();
        #1;
        check("stalled_valid", {out_valid, busy}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        #1;
        check("after_rst_step_count", step_count, 0);
        check("after_rst_en", cpu_en, 0);
        check("after_rst_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
